// File: rtl/k68_sasc_pkg.sv
// Shared types and constants for the k68 SASC bus host.
package k68_sasc_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned STAT_W    = 10;
    localparam int unsigned BUS_W     = 24;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned FULL_BIT  = 9;
    localparam int unsigned EMPTY_BIT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // Write-data word presented to the peripheral.
    typedef struct packed {
        logic [BYTE_W-1:0] div1;
        logic [BYTE_W-1:0] div0;
        logic [BYTE_W-1:0] tx_byte;
    } bus_word_t;

endpackage

// File: rtl/k68_sasc_host_arb.sv
// Round-robin grant between TX writes and RX reads, evaluated in IDLE.
module k68_sasc_host_arb (
    input  logic idle,
    input  logic rst,
    input  logic tx_ok,
    input  logic rx_ok,
    input  logic last_tx,
    input  logic tx_vld,
    output logic tx_rdy,
    output logic rd_go
);

    // TX yields only when RX is eligible and TX was served last; read fires when no TX transfer happens.
    always_comb begin
        tx_rdy = idle & tx_ok & ~(rx_ok & last_tx) & ~rst;
        rd_go  = idle & rx_ok & ~(tx_vld & tx_rdy) & ~rst;
    end

endmodule

// File: rtl/k68_sasc_host.sv
// Bus initiator that feeds the SASC TX FIFO and drains its RX FIFO into a one-entry output register.
module k68_sasc_host
    import k68_sasc_pkg::*;
#(
    parameter logic [7:0]  DIV0       = 8'd1,
    parameter logic [7:0]  DIV1       = 8'd217,
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [BYTE_W-1:0] tx_dat_i,
    input  logic              tx_vld_i,
    output logic              tx_rdy_o,
    output logic [BYTE_W-1:0] rx_dat_o,
    output logic              rx_vld_o,
    input  logic              rx_rdy_i,
    output logic              cs_o,
    output logic              we_o,
    output logic [BUS_W-1:0]  dat_o,
    input  logic [STAT_W-1:0] dat_i,
    output logic              busy_o
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_tx_q, last_tx_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic [BYTE_W-1:0] rx_dat_d;
    logic              rx_vld_d;
    logic              cs_d, we_d, busy_d;
    logic              tx_ok, rx_ok, rd_go, tx_go;
    bus_word_t         bus_word;

    // Eligibility from the peripheral status word.
    always_comb begin
        tx_ok = ~dat_i[FULL_BIT];
        rx_ok = ~dat_i[EMPTY_BIT] & ~rx_vld_o;
        tx_go = tx_vld_i & tx_rdy_o;
    end

    k68_sasc_host_arb u_arb (
        .idle    (state_q == IDLE),
        .rst     (rst_i),
        .tx_ok   (tx_ok),
        .rx_ok   (rx_ok),
        .last_tx (last_tx_q),
        .tx_vld  (tx_vld_i),
        .tx_rdy  (tx_rdy_o),
        .rd_go   (rd_go)
    );

    // Divisors are constant so the baud generator sees a stable value.
    always_comb begin
        bus_word = '{div1: DIV1, div0: DIV0, tx_byte: byte_q};
        dat_o    = bus_word;
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_tx_d = last_tx_q;
        byte_d    = byte_q;
        rx_dat_d  = rx_dat_o;
        rx_vld_d  = rx_vld_o;
        cs_d      = 1'b0;
        we_d      = 1'b0;

        if (rx_vld_o && rx_rdy_i) begin
            rx_vld_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (tx_go) begin
                    cs_d      = 1'b1;
                    we_d      = 1'b1;
                    byte_d    = tx_dat_i;
                    last_tx_d = 1'b1;
                    state_d   = STROBE;
                end else if (rd_go) begin
                    cs_d      = 1'b1;
                    last_tx_d = 1'b0;
                    state_d   = STROBE;
                end
            end
            STROBE: begin
                // RX head is valid before the pop takes effect.
                if (!we_o) begin
                    rx_dat_d = dat_i[BYTE_W-1:0];
                    rx_vld_d = 1'b1;
                end
                cnt_d   = SETTLE_LD;
                state_d = SETTLE;
            end
            SETTLE: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_tx_q <= 1'b0;
            byte_q    <= '0;
            rx_dat_o  <= '0;
            rx_vld_o  <= 1'b0;
            cs_o      <= 1'b0;
            we_o      <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_tx_q <= last_tx_d;
            byte_q    <= byte_d;
            rx_dat_o  <= rx_dat_d;
            rx_vld_o  <= rx_vld_d;
            cs_o      <= cs_d;
            we_o      <= we_d;
            busy_o    <= busy_d;
        end
    end

endmodule

// File: tb/tb_k68_sasc_host.sv
// Directed bench for k68_sasc_host with a strobe/RX scoreboard.
module tb_k68_sasc_host;
    import k68_sasc_pkg::*;

    localparam int unsigned SETTLE = 1;

    typedef struct packed {
        logic       we;
        logic [7:0] dat;
    } strobe_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  tx_dat_i = 8'h00;
    logic        tx_vld_i = 1'b0;
    logic        tx_rdy_o;
    logic [7:0]  rx_dat_o;
    logic        rx_vld_o;
    logic        rx_rdy_i = 1'b0;
    logic        cs_o;
    logic        we_o;
    logic [23:0] dat_o;
    logic [9:0]  dat_i = 10'h100;
    logic        busy_o;

    int vectors = 0;
    int miscompares = 0;

    strobe_t    sq[$];
    logic [7:0] rq[$];

    always #5 clk = ~clk;

    k68_sasc_host #(.DIV0(8'd1), .DIV1(8'd217), .SETTLE_CYC(SETTLE)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .tx_dat_i (tx_dat_i),
        .tx_vld_i (tx_vld_i),
        .tx_rdy_o (tx_rdy_o),
        .rx_dat_o (rx_dat_o),
        .rx_vld_o (rx_vld_o),
        .rx_rdy_i (rx_rdy_i),
        .cs_o     (cs_o),
        .we_o     (we_o),
        .dat_o    (dat_o),
        .dat_i    (dat_i),
        .busy_o   (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard: every strobe and every consumed RX byte must match a queued expectation.
    always @(negedge clk) begin
        strobe_t    e;
        logic [7:0] r;
        chk("we_without_cs", 32'(we_o & ~cs_o), 32'd0);
        if (cs_o) begin
            if (sq.size() == 0) begin
                chk("spurious_strobe", 32'(cs_o), 32'd0);
            end else begin
                e = sq.pop_front();
                chk("strobe_we", 32'(we_o), 32'(e.we));
                if (e.we) chk("strobe_dat", 32'(dat_o), 32'({8'hD9, 8'h01, e.dat}));
            end
        end
        if (rx_vld_o && rx_rdy_i) begin
            if (rq.size() == 0) begin
                chk("spurious_rx", 32'(rx_vld_o), 32'd0);
            end else begin
                r = rq.pop_front();
                chk("rx_byte", 32'(rx_dat_o), 32'(r));
            end
        end
    end

    initial begin
        int   nstr;
        int   cyc;
        int   last_cyc;
        logic acc;

        // Reset values
        repeat (3) adv();
        smp();
        chk("rst_cs", 32'(cs_o), 32'd0);
        chk("rst_we", 32'(we_o), 32'd0);
        chk("rst_dat", 32'(dat_o), 32'hD90100);
        chk("rst_rx_vld", 32'(rx_vld_o), 32'd0);
        chk("rst_rx_dat", 32'(rx_dat_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_tx_rdy", 32'(tx_rdy_o), 32'd0);
        adv();
        rst_i = 1'b0;
        smp();
        chk("idle_tx_rdy", 32'(tx_rdy_o), 32'd1);
        chk("idle_cs", 32'(cs_o), 32'd0);

        // Single TX byte
        adv();
        tx_dat_i = 8'h41;
        tx_vld_i = 1'b1;
        sq.push_back('{we: 1'b1, dat: 8'h41});
        smp();
        chk("tx_rdy_accept", 32'(tx_rdy_o), 32'd1);
        adv();
        tx_vld_i = 1'b0;
        smp();
        chk("wr_cs", 32'(cs_o), 32'd1);
        chk("wr_we", 32'(we_o), 32'd1);
        chk("wr_dat", 32'(dat_o), 32'hD90141);
        chk("wr_tx_rdy", 32'(tx_rdy_o), 32'd0);
        chk("wr_busy", 32'(busy_o), 32'd1);
        adv();
        smp();
        chk("settle_cs", 32'(cs_o), 32'd0);
        chk("settle_tx_rdy", 32'(tx_rdy_o), 32'd0);
        chk("settle_busy", 32'(busy_o), 32'd1);
        adv();
        smp();
        chk("back_idle_tx_rdy", 32'(tx_rdy_o), 32'd1);
        chk("back_idle_busy", 32'(busy_o), 32'd0);
        chk("dat_hold", 32'(dat_o), 32'hD90141);

        // TX FIFO full holds off the write
        adv();
        dat_i = 10'h300;
        tx_dat_i = 8'h77;
        tx_vld_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            smp();
            chk("full_tx_rdy", 32'(tx_rdy_o), 32'd0);
            chk("full_cs", 32'(cs_o), 32'd0);
            adv();
        end
        dat_i = 10'h100;
        sq.push_back('{we: 1'b1, dat: 8'h77});
        smp();
        chk("unfull_tx_rdy", 32'(tx_rdy_o), 32'd1);
        adv();
        tx_vld_i = 1'b0;
        smp();
        chk("unfull_wr_cs", 32'(cs_o), 32'd1);
        chk("unfull_wr_dat", 32'(dat_o), 32'hD90177);
        adv();
        adv();

        // RX read, held until consumed
        dat_i = 10'h05A;
        sq.push_back('{we: 1'b0, dat: 8'h00});
        rq.push_back(8'h5A);
        smp();
        chk("rx_wins_tx_rdy", 32'(tx_rdy_o), 32'd0);
        adv();
        smp();
        chk("rd_cs", 32'(cs_o), 32'd1);
        chk("rd_we", 32'(we_o), 32'd0);
        adv();
        smp();
        chk("rd_rx_vld", 32'(rx_vld_o), 32'd1);
        chk("rd_rx_dat", 32'(rx_dat_o), 32'h5A);
        for (int i = 0; i < 5; i++) begin
            adv();
            smp();
            chk("hold_rx_vld", 32'(rx_vld_o), 32'd1);
            chk("hold_cs", 32'(cs_o), 32'd0);
        end
        adv();
        rx_rdy_i = 1'b1;
        smp();
        adv();
        rx_rdy_i = 1'b0;
        dat_i = 10'h0A5;
        sq.push_back('{we: 1'b0, dat: 8'h00});
        rq.push_back(8'hA5);
        smp();
        chk("consumed_rx_vld", 32'(rx_vld_o), 32'd0);
        adv();
        smp();
        chk("rd2_cs", 32'(cs_o), 32'd1);
        adv();
        smp();
        chk("rd2_rx_vld", 32'(rx_vld_o), 32'd1);
        chk("rd2_rx_dat", 32'(rx_dat_o), 32'hA5);
        adv();
        rx_rdy_i = 1'b1;
        dat_i = 10'h100;
        adv();
        rx_rdy_i = 1'b0;
        smp();
        chk("rd2_consumed", 32'(rx_vld_o), 32'd0);

        // Continuous TX and RX: strict W/R alternation
        for (int k = 0; k < 8; k++) begin
            sq.push_back('{we: 1'b1, dat: 8'(16 + k)});
            sq.push_back('{we: 1'b0, dat: 8'h00});
            rq.push_back(8'hC3);
        end
        adv();
        tx_dat_i = 8'h10;
        tx_vld_i = 1'b1;
        dat_i = 10'h0C3;
        rx_rdy_i = 1'b1;
        nstr = 0;
        cyc = 0;
        last_cyc = 0;
        while (nstr < 16 && cyc < 200) begin
            smp();
            acc = tx_vld_i & tx_rdy_o;
            if (cs_o) begin
                if (nstr > 0) chk("strobe_gap", 32'(cyc - last_cyc), 32'(2 + SETTLE));
                last_cyc = cyc;
                nstr++;
            end
            adv();
            cyc++;
            if (acc) tx_dat_i = tx_dat_i + 8'd1;
        end
        tx_vld_i = 1'b0;
        dat_i = 10'h100;
        chk("strobe_count", 32'(nstr), 32'd16);
        repeat (4) adv();
        rx_rdy_i = 1'b0;
        smp();
        chk("sq_drained", 32'(sq.size()), 32'd0);
        chk("rq_drained", 32'(rq.size()), 32'd0);
        chk("alt_rx_vld", 32'(rx_vld_o), 32'd0);

        // Reset during a read strobe
        adv();
        dat_i = 10'h066;
        sq.push_back('{we: 1'b0, dat: 8'h00});
        smp();
        adv();
        smp();
        chk("rstrd_cs", 32'(cs_o), 32'd1);
        chk("rstrd_we", 32'(we_o), 32'd0);
        rst_i = 1'b1;
        adv();
        smp();
        chk("rstrd_cs_drop", 32'(cs_o), 32'd0);
        chk("rstrd_we_drop", 32'(we_o), 32'd0);
        chk("rstrd_rx_vld", 32'(rx_vld_o), 32'd0);
        chk("rstrd_dat", 32'(dat_o), 32'hD90100);
        chk("rstrd_busy", 32'(busy_o), 32'd0);
        chk("rstrd_tx_rdy", 32'(tx_rdy_o), 32'd0);
        adv();
        rst_i = 1'b0;
        dat_i = 10'h100;
        smp();
        chk("post_rst_tx_rdy", 32'(tx_rdy_o), 32'd1);
        chk("post_rst_rx_vld", 32'(rx_vld_o), 32'd0);
        chk("post_rst_sq", 32'(sq.size()), 32'd0);
        adv();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
